// File: rtl/pwm_seq_ctrl.sv
// PWM sequencer: programs a PWM wrapper over OPB, polls its status,
// retries after over-current faults and locks out after too many.
module pwm_seq_ctrl #(
    parameter int unsigned POLL_DIV  = 1000,
    parameter int unsigned RETRY_DLY = 100000,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic         OPB_CLK,
    input  logic         OPB_RST_N,
    input  logic         start_i,
    input  logic         stop_i,
    input  logic [31:0]  cfg_i,
    input  logic [127:0] param_i,
    output logic         m_we_o,
    output logic         m_re_o,
    output logic [3:0]   m_addr_o,
    output logic [31:0]  m_di_o,
    input  logic [31:0]  m_do_i,
    output logic         busy_o,
    output logic         fault_o,
    output logic         lockout_o,
    output logic         done_o,
    output logic [3:0]   retry_cnt_o
);

    typedef enum logic [2:0] {
        IDLE, LOAD, RUN, POLL, FAULT_WAIT, RESTART, STOP, LOCKOUT
    } state_t;

    localparam logic [31:0] RUN_LAST  = 32'(POLL_DIV - 1);
    localparam logic [31:0] WAIT_LAST = 32'(RETRY_DLY - 1);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

    state_t        state_q;
    state_t        state_d;
    logic [31:0]   cnt_q;
    logic [31:0]   cfg_q;
    logic [127:0]  par_q;
    logic          fault_q;
    logic [3:0]    retry_q;
    logic          stop_pend_q;
    logic          armed_q;

    logic          flt;
    logic          poll_eval;
    logic          stop_now;
    logic [28:0]   unused_status;

    assign flt           = |m_do_i[2:1];
    assign poll_eval     = (state_q == POLL) && (cnt_q == 32'd1);
    assign stop_now      = stop_i | stop_pend_q;
    assign unused_status = m_do_i[31:3];

    // State register
    always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
        if (!OPB_RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decision
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (stop_i)
                    state_d = STOP;
                else if (start_i && armed_q)
                    state_d = LOAD;
            end
            LOAD: begin
                if (stop_i)
                    state_d = STOP;
                else if (cnt_q == 32'd5)
                    state_d = RUN;
            end
            RUN: begin
                if (stop_i)
                    state_d = STOP;
                else if (cnt_q == RUN_LAST)
                    state_d = POLL;
            end
            POLL: begin
                if (cnt_q != 32'd0) begin
                    if (stop_now)
                        state_d = STOP;
                    else if (flt)
                        state_d = (retry_q < RETRY_MAX) ? FAULT_WAIT : LOCKOUT;
                    else if (m_do_i[0])
                        state_d = RUN;
                    else
                        state_d = IDLE;
                end
            end
            FAULT_WAIT: begin
                if (stop_i)
                    state_d = STOP;
                else if (cnt_q == WAIT_LAST)
                    state_d = RESTART;
            end
            RESTART: state_d = stop_i ? STOP : RUN;
            STOP:    state_d = IDLE;
            LOCKOUT: begin
                if (stop_i)
                    state_d = STOP;
            end
            default: state_d = IDLE;
        endcase
    end

    // Phase counter, captured parameters, fault flag and retry count
    always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
        if (!OPB_RST_N) begin
            cnt_q       <= '0;
            cfg_q       <= '0;
            par_q       <= '0;
            fault_q     <= 1'b0;
            retry_q     <= '0;
            stop_pend_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            cnt_q       <= (state_d != state_q) ? '0 : cnt_q + 32'd1;
            armed_q     <= 1'b1;
            stop_pend_q <= (state_q == POLL) && (cnt_q == 32'd0) && stop_i;
            if (state_q == IDLE && state_d == LOAD) begin
                cfg_q   <= cfg_i;
                par_q   <= param_i;
                fault_q <= 1'b0;
            end else if (state_q == STOP) begin
                fault_q <= 1'b0;
            end else if (poll_eval && !stop_now) begin
                fault_q <= flt;
            end
            if (state_q == STOP)
                retry_q <= '0;
            else if (state_q == LOAD && state_d == RUN)
                retry_q <= '0;
            else if (state_q == RESTART && retry_q != 4'hF)
                retry_q <= retry_q + 4'd1;
        end
    end

    // Bus strobes and status outputs decoded from the current state
    always_comb begin
        m_we_o      = 1'b0;
        m_re_o      = 1'b0;
        m_addr_o    = 4'h0;
        m_di_o      = 32'h0;
        busy_o      = (state_q != IDLE);
        lockout_o   = (state_q == LOCKOUT);
        fault_o     = fault_q;
        retry_cnt_o = retry_q;
        done_o      = poll_eval && !stop_now && (m_do_i[2:0] == 3'b000);
        unique case (state_q)
            LOAD: begin
                m_we_o   = 1'b1;
                m_addr_o = cnt_q[3:0];
                unique case (cnt_q[2:0])
                    3'd0:    m_di_o = cfg_q;
                    3'd1:    m_di_o = par_q[31:0];
                    3'd2:    m_di_o = par_q[63:32];
                    3'd3:    m_di_o = par_q[95:64];
                    3'd4:    m_di_o = par_q[127:96];
                    default: m_di_o = 32'h1;
                endcase
            end
            POLL: begin
                if (cnt_q == 32'd0) begin
                    m_re_o   = 1'b1;
                    m_addr_o = 4'h6;
                end
            end
            RESTART: begin
                m_we_o   = 1'b1;
                m_addr_o = 4'h5;
                m_di_o   = 32'h1;
            end
            STOP: begin
                m_we_o   = 1'b1;
                m_addr_o = 4'h5;
                m_di_o   = 32'h2;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Testbench for pwm_seq_ctrl: expected OPB accesses are queued by the
// stimulus and checked against the bus by an independent monitor.
module tb_pwm_seq_ctrl;

    localparam int P = 5;
    localparam int R = 4;
    localparam int M = 3;

    logic         OPB_CLK = 1'b0;
    logic         OPB_RST_N = 1'b0;
    logic         start_i = 1'b0;
    logic         stop_i = 1'b0;
    logic [31:0]  cfg_i = '0;
    logic [127:0] param_i = '0;
    logic         m_we_o;
    logic         m_re_o;
    logic [3:0]   m_addr_o;
    logic [31:0]  m_di_o;
    logic [31:0]  m_do_i = '0;
    logic         busy_o;
    logic         fault_o;
    logic         lockout_o;
    logic         done_o;
    logic [3:0]   retry_cnt_o;

    pwm_seq_ctrl #(.POLL_DIV(P), .RETRY_DLY(R), .MAX_RETRY(M)) dut (
        .OPB_CLK(OPB_CLK), .OPB_RST_N(OPB_RST_N),
        .start_i(start_i), .stop_i(stop_i),
        .cfg_i(cfg_i), .param_i(param_i),
        .m_we_o(m_we_o), .m_re_o(m_re_o),
        .m_addr_o(m_addr_o), .m_di_o(m_di_o), .m_do_i(m_do_i),
        .busy_o(busy_o), .fault_o(fault_o), .lockout_o(lockout_o),
        .done_o(done_o), .retry_cnt_o(retry_cnt_o)
    );

    always #5 OPB_CLK = ~OPB_CLK;

    int cyc = 0;
    always @(posedge OPB_CLK) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic        we;
        logic        re;
        logic [3:0]  a;
        logic [31:0] d;
    } acc_t;

    acc_t exp_q[$];
    int   plan[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic void push(int c, logic we, logic re,
                                 logic [3:0] a, logic [31:0] d);
        acc_t e;
        e.c = c; e.we = we; e.re = re; e.a = a; e.d = d;
        exp_q.push_back(e);
    endfunction

    task automatic tick();
        @(posedge OPB_CLK);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    function automatic int fstat();
        int b;
        b = $urandom_range(1, 3);
        return (b << 1) | $urandom_range(0, 1);
    endfunction

    // Bus monitor
    initial begin
        acc_t e;
        forever begin
            @(negedge OPB_CLK);
            if (OPB_RST_N) begin
                while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
                    e = exp_q.pop_front();
                    tests++;
                    fails++;
                    $display("FAIL missing_access: addr %0h data %0h due cycle %0d, not observed",
                             e.a, e.d, e.c);
                end
                chk("we_re_exclusive", 32'(m_we_o & m_re_o), 0);
                if (m_we_o || m_re_o) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_access: we %0b re %0b addr %0h data %0h at cycle %0d, required none",
                                 m_we_o, m_re_o, m_addr_o, m_di_o, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("acc_cycle", 32'(cyc), 32'(e.c));
                        chk("acc_we", 32'(m_we_o), 32'(e.we));
                        chk("acc_re", 32'(m_re_o), 32'(e.re));
                        chk("acc_addr", 32'(m_addr_o), 32'(e.a));
                        if (e.we)
                            chk("acc_data", m_di_o, e.d);
                    end
                end else begin
                    chk("idle_addr", 32'(m_addr_o), 0);
                    chk("idle_data", m_di_o, 0);
                end
            end
        end
    end

    task automatic start_load(input logic [31:0] cfg,
                              input logic [127:0] par, output int s);
        s = cyc;
        cfg_i = cfg;
        param_i = par;
        start_i = 1'b1;
        push(s + 1, 1, 0, 4'h0, cfg);
        push(s + 2, 1, 0, 4'h1, par[31:0]);
        push(s + 3, 1, 0, 4'h2, par[63:32]);
        push(s + 4, 1, 0, 4'h3, par[95:64]);
        push(s + 5, 1, 0, 4'h4, par[127:96]);
        push(s + 6, 1, 0, 4'h5, 32'h1);
        tick();
        start_i = 1'b0;
        cfg_i = $urandom();
        param_i = {$urandom(), $urandom(), $urandom(), $urandom()};
        chk("load_busy", 32'(busy_o), 1);
    endtask

    // kind: 0 done, 1 lockout, 2 running from r, 3 fault wait from r
    task automatic run_polls(input int r0, output int kind, output int r);
        int t;
        int retries;
        logic [2:0] st;
        r = r0;
        retries = 0;
        kind = 2;
        for (int i = 0; i < plan.size(); i++) begin
            t = r + P;
            push(t, 0, 1, 4'h6, 32'h0);
            goto(t);
            st = 3'(plan[i]);
            m_do_i = ($urandom() & 32'hFFFF_FFF8) | {29'd0, st};
            goto(t + 1);
            if (st[2:1] != 2'b00) begin
                chk("fault_no_done", 32'(done_o), 0);
                if (retries < M) begin
                    goto(t + 2);
                    chk("fault_set", 32'(fault_o), 1);
                    chk("fault_busy", 32'(busy_o), 1);
                    chk("fault_no_lock", 32'(lockout_o), 0);
                    if (i == plan.size() - 1) begin
                        kind = 3;
                        r = t + 2;
                        return;
                    end
                    push(t + 2 + R, 1, 0, 4'h5, 32'h1);
                    goto(t + 3 + R);
                    retries++;
                    chk("retry_cnt", 32'(retry_cnt_o), 32'(retries));
                    chk("fault_hold", 32'(fault_o), 1);
                    r = t + 3 + R;
                end else begin
                    goto(t + 2);
                    chk("lockout_set", 32'(lockout_o), 1);
                    chk("lockout_fault", 32'(fault_o), 1);
                    chk("lockout_busy", 32'(busy_o), 1);
                    chk("lockout_retry", 32'(retry_cnt_o), 32'(M));
                    kind = 1;
                    return;
                end
            end else if (st[0]) begin
                chk("run_no_done", 32'(done_o), 0);
                goto(t + 2);
                chk("run_fault_clr", 32'(fault_o), 0);
                chk("run_retry", 32'(retry_cnt_o), 32'(retries));
                r = t + 2;
            end else begin
                chk("done_pulse", 32'(done_o), 1);
                chk("done_busy", 32'(busy_o), 1);
                goto(t + 2);
                chk("done_low", 32'(done_o), 0);
                chk("done_idle", 32'(busy_o), 0);
                chk("done_fault", 32'(fault_o), 0);
                kind = 0;
                return;
            end
        end
    endtask

    task automatic do_stop();
        int c;
        c = cyc;
        stop_i = 1'b1;
        push(c + 1, 1, 0, 4'h5, 32'h2);
        tick();
        stop_i = 1'b0;
        chk("stop_lock_clr", 32'(lockout_o), 0);
        goto(c + 2);
        chk("stop_idle", 32'(busy_o), 0);
        chk("stop_fault", 32'(fault_o), 0);
        chk("stop_retry", 32'(retry_cnt_o), 0);
        chk("stop_lock", 32'(lockout_o), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int k;
        int r;
        int t;
        int c;
        int n;

        repeat (3) @(posedge OPB_CLK);
        #1;
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_fault", 32'(fault_o), 0);
        chk("rst_lock", 32'(lockout_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_we", 32'(m_we_o), 0);
        chk("rst_re", 32'(m_re_o), 0);
        chk("rst_retry", 32'(retry_cnt_o), 0);

        @(negedge OPB_CLK);
        OPB_RST_N = 1'b1;
        start_i = 1'b1;
        cfg_i = $urandom();
        tick();
        start_i = 1'b0;
        chk("early_start_ignored", 32'(busy_o), 0);

        start_load(32'h3, {32'd100, 32'd100, 32'd200, 32'd300}, s);
        plan.delete();
        plan.push_back(1); plan.push_back(1); plan.push_back(0);
        run_polls(s + 7, k, r);
        chk("seq_a_kind", 32'(k), 0);

        start_load($urandom(), {$urandom(), $urandom(), $urandom(), $urandom()}, s);
        plan.delete();
        plan.push_back(3); plan.push_back(1); plan.push_back(0);
        run_polls(s + 7, k, r);
        chk("seq_b_kind", 32'(k), 0);

        start_load($urandom(), {$urandom(), $urandom(), $urandom(), $urandom()}, s);
        plan.delete();
        for (int i = 0; i < 4; i++) plan.push_back(fstat());
        run_polls(s + 7, k, r);
        chk("seq_c_kind", 32'(k), 1);
        goto(cyc + 15);
        chk("lockout_hold", 32'(lockout_o), 1);
        do_stop();

        s = cyc;
        cfg_i = $urandom();
        param_i = {$urandom(), $urandom(), $urandom(), $urandom()};
        start_i = 1'b1;
        push(s + 1, 1, 0, 4'h0, cfg_i);
        push(s + 2, 1, 0, 4'h1, param_i[31:0]);
        push(s + 3, 1, 0, 4'h2, param_i[63:32]);
        push(s + 4, 1, 0, 4'h5, 32'h2);
        tick();
        start_i = 1'b0;
        goto(s + 3);
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        goto(s + 5);
        chk("load_stop_idle", 32'(busy_o), 0);

        c = cyc;
        start_i = 1'b1;
        stop_i = 1'b1;
        push(c + 1, 1, 0, 4'h5, 32'h2);
        tick();
        start_i = 1'b0;
        stop_i = 1'b0;
        goto(c + 2);
        chk("start_stop_idle", 32'(busy_o), 0);
        goto(c + 12);

        start_load($urandom(), {$urandom(), $urandom(), $urandom(), $urandom()}, s);
        plan.delete();
        plan.push_back(fstat()); plan.push_back(1);
        run_polls(s + 7, k, r);
        chk("seq_run_kind", 32'(k), 2);
        goto(r + $urandom_range(0, P - 1));
        do_stop();

        start_load($urandom(), {$urandom(), $urandom(), $urandom(), $urandom()}, s);
        plan.delete();
        plan.push_back(1);
        run_polls(s + 7, k, r);
        t = r + P;
        push(t, 0, 1, 4'h6, 32'h0);
        goto(t);
        m_do_i = 32'h0;
        stop_i = 1'b1;
        push(t + 2, 1, 0, 4'h5, 32'h2);
        tick();
        stop_i = 1'b0;
        chk("poll_stop_no_done", 32'(done_o), 0);
        goto(t + 3);
        chk("poll_stop_idle", 32'(busy_o), 0);

        start_load($urandom(), {$urandom(), $urandom(), $urandom(), $urandom()}, s);
        plan.delete();
        plan.push_back(fstat());
        run_polls(s + 7, k, r);
        chk("seq_fw_kind", 32'(k), 3);
        goto(r + 1);
        #1;
        OPB_RST_N = 1'b0;
        #1;
        chk("arst_busy", 32'(busy_o), 0);
        chk("arst_fault", 32'(fault_o), 0);
        chk("arst_retry", 32'(retry_cnt_o), 0);
        chk("arst_we", 32'(m_we_o), 0);
        chk("arst_lock", 32'(lockout_o), 0);
        chk("arst_queue", 32'(exp_q.size()), 0);
        @(negedge OPB_CLK);
        @(negedge OPB_CLK);
        OPB_RST_N = 1'b1;
        tick();
        start_load($urandom(), {$urandom(), $urandom(), $urandom(), $urandom()}, s);
        plan.delete();
        plan.push_back(0);
        run_polls(s + 7, k, r);
        chk("post_rst_kind", 32'(k), 0);

        for (int it = 0; it < 8; it++) begin
            plan.delete();
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) begin
                if (i == n - 1)
                    plan.push_back(($urandom_range(0, 1) == 1) ? 0 : fstat());
                else
                    plan.push_back(($urandom_range(0, 1) == 1) ? 1 : fstat());
            end
            start_load($urandom(), {$urandom(), $urandom(), $urandom(), $urandom()}, s);
            run_polls(s + 7, k, r);
            if (k == 1) begin
                do_stop();
            end else if (k == 3) begin
                goto(r + $urandom_range(0, R - 1));
                do_stop();
            end else if (k == 2) begin
                do_stop();
            end
            goto(cyc + $urandom_range(1, 4));
        end

        goto(cyc + 5);
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
